matrix_memory_unit: RTL and testbench
=====================================

Name: matrix_memory_unit

Overview:
- Downstream of the execution engine; consumes its memory control outputs (nMem_Enable, mem_RW, mem_address).
- Holds DEPTH matrix registers, each ELEMS elements of DATA_WIDTH bits (4x4 of 16-bit by default).
- Streams one whole matrix per command, one element per clock: reads go to the ALU datapath, writes come from it.
- Provides a busy/done handshake so the engine can sequence multi-cycle transfers.

Parameters:
- DATA_WIDTH, 16, element width in bits
- ADDR_WIDTH, 3, matrix register address width; DEPTH = 2**ADDR_WIDTH = 8
- ELEMS, 16, elements per matrix (4x4); index width = 4

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- nMem_Enable  in  1  active-low command strobe from the execution engine
- mem_RW  in  1  1 = read matrix out, 0 = write matrix in
- mem_address  in  ADDR_WIDTH  matrix register select
- data_in  in  DATA_WIDTH  write element from the ALU datapath
- data_in_valid  in  1  data_in holds a valid element this cycle
- data_in_ready  out  1  unit accepts write elements (state == WRITE)
- data_out  out  DATA_WIDTH  read element (registered)
- data_out_valid  out  1  data_out holds a valid element (registered)
- elem_index  out  4  index of the next element to transfer
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse when a transfer completes

Behaviour:
Reset:
- reset = 0 asynchronously forces state = IDLE and clears elem_index, data_out, data_out_valid and done to 0.
- Reset also clears every memory element to 0.
- busy = 0 and data_in_ready = 0 while reset is asserted.

States: IDLE, READ, WRITE, FINISH.

IDLE:
- At a rising edge with nMem_Enable = 0, the unit latches mem_address and mem_RW and sets elem_index = 0.
- Next state is READ if mem_RW = 1, otherwise WRITE.
- nMem_Enable = 1 keeps the unit in IDLE.

Command rules:
- nMem_Enable is sampled only in IDLE; strobes in READ, WRITE or FINISH are ignored.
- A held-low strobe is never queued or re-accepted mid-transfer.
- Inputs to a running transfer are the latched address and direction only.

READ:
- Acceptance edge = E0. At each edge E1..E16: data_out <= mem[addr][elem_index], data_out_valid <= 1, elem_index increments.
- At E16 (element 15 output) state becomes FINISH and elem_index wraps to 0.
- Read has no stall; the consumer must take one element per cycle.

WRITE:
- data_in_ready = 1 combinationally while in this state.
- At each edge with data_in_valid = 1: mem[addr][elem_index] <= data_in and elem_index increments.
- With data_in_valid = 0 the edge writes nothing and elem_index holds.
- Writing element 15 moves the state to FINISH.

FINISH:
- At the next edge: done <= 1, data_out_valid <= 0, state becomes IDLE.
- done clears at the following edge.
- The earliest new command is accepted at the edge after done rises.

Timing and ordering:
- Unstalled latency: command to done is 17 cycles for both read and write.
- data_out holds its last value when data_out_valid = 0.
- Write-then-read to the same address returns the new data.
- No other matrix register is disturbed by a transfer.

Test Plan:
1. Release reset; read addr 3 -> data_out_valid high E1..E16, all data_out = 0x0000, done pulse at E17, busy low at E17.
2. Write addr 2 with data_in = 0x1000+i, valid every cycle, then read addr 2 -> data_out sequence 0x1000..0x100F on E1..E16, done at E17 for both transfers.
3. Write addr 5, drop data_in_valid for 3 cycles after element 5 -> elem_index holds at 6 with no writes during the gap; done at E20; read-back of addr 5 is correct.
4. Keep nMem_Enable low for the whole of a read of addr 1 while toggling mem_address and mem_RW -> transfer still addresses addr 1; a new command is accepted only at the edge after done rises.
5. Assert reset mid-read after element 7 -> data_out, data_out_valid, busy and elem_index go to 0 immediately without waiting for a clock edge; a subsequent read of a previously written address returns zeros.
6. Write 0xFFFF to all of addr 7, then read addr 0 and addr 6 -> both unaffected (zeros); read addr 7 -> all 0xFFFF.

Source files
------------

// File: rtl/matrix_memory_unit.sv
// rtl/matrix_memory_unit.sv - matrix register file streaming one element per clock
// Holds DEPTH matrices; each command reads out or writes in a whole matrix.
module matrix_memory_unit #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 3,
   parameter int ELEMS      = 16
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      nMem_Enable,
   input  logic                      mem_RW,
   input  logic [ADDR_WIDTH-1:0]     mem_address,
   input  logic [DATA_WIDTH-1:0]     data_in,
   input  logic                      data_in_valid,
   output logic                      data_in_ready,
   output logic [DATA_WIDTH-1:0]     data_out,
   output logic                      data_out_valid,
   output logic [$clog2(ELEMS)-1:0]  elem_index,
   output logic                      busy,
   output logic                      done
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;
   localparam int IDX_W = $clog2(ELEMS);
   localparam logic [IDX_W-1:0] LAST = IDX_W'(ELEMS - 1);

   typedef enum logic [1:0] {IDLE, READ, WRITE, FINISH} state_t;

   state_t                  state;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic [DATA_WIDTH-1:0]   mem [DEPTH][ELEMS];
   logic                    write_en;

   assign busy          = (state != IDLE);
   assign data_in_ready = (state == WRITE);
   assign write_en      = (state == WRITE) && data_in_valid;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int d = 0; d < DEPTH; d++)
            for (int e = 0; e < ELEMS; e++)
               mem[d][e] <= '0;
      end else if (write_en) begin
         mem[addr_q][elem_index] <= data_in;
      end
   end

   // Direction is encoded in the state itself; only the address needs latching.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state          <= IDLE;
         addr_q         <= '0;
         elem_index     <= '0;
         data_out       <= '0;
         data_out_valid <= 1'b0;
         done           <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (!nMem_Enable) begin
                  addr_q     <= mem_address;
                  elem_index <= '0;
                  state      <= mem_RW ? READ : WRITE;
               end
            end
            READ: begin
               data_out       <= mem[addr_q][elem_index];
               data_out_valid <= 1'b1;
               if (elem_index == LAST) begin
                  elem_index <= '0;
                  state      <= FINISH;
               end else begin
                  elem_index <= elem_index + 1'b1;
               end
            end
            WRITE: begin
               if (data_in_valid) begin
                  if (elem_index == LAST) begin
                     elem_index <= '0;
                     state      <= FINISH;
                  end else begin
                     elem_index <= elem_index + 1'b1;
                  end
               end
            end
            FINISH: begin
               done           <= 1'b1;
               data_out_valid <= 1'b0;
               state          <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_matrix_memory_unit.sv
// tb/tb_matrix_memory_unit.sv - scoreboard bench for matrix_memory_unit
module tb_matrix_memory_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        nMem_Enable = 1'b1;
   logic        mem_RW = 1'b0;
   logic [2:0]  mem_address = '0;
   logic [15:0] data_in = '0;
   logic        data_in_valid = 1'b0;
   logic        data_in_ready;
   logic [15:0] data_out;
   logic        data_out_valid;
   logic [3:0]  elem_index;
   logic        busy;
   logic        done;

   matrix_memory_unit dut (
      .clk(clk), .reset(reset), .nMem_Enable(nMem_Enable), .mem_RW(mem_RW),
      .mem_address(mem_address), .data_in(data_in), .data_in_valid(data_in_valid),
      .data_in_ready(data_in_ready), .data_out(data_out), .data_out_valid(data_out_valid),
      .elem_index(elem_index), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0;
   int bad = 0;
   logic [15:0] exp_q [$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (reset && data_out_valid) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_data: got %0h want none", data_out);
         end else begin
            chk("data_out", {16'h0, data_out}, {16'h0, exp_q.pop_front()});
         end
      end
   end

   task automatic wait_done(input int start, input int lat, input string name);
      bit seen = 0;
      for (int n = 0; n < 60; n++) begin
         @(negedge clk);
         if (done) begin
            seen = 1;
            break;
         end
      end
      if (!seen) begin
         total++;
         bad++;
         $display("FAIL %s_timeout: got no done want done", name);
      end else begin
         chk({name, "_lat"}, cyc - start, lat);
         chk({name, "_busy"}, {31'h0, busy}, 0);
         chk({name, "_valid"}, {31'h0, data_out_valid}, 0);
      end
   endtask

   task automatic issue(input logic rw, input logic [2:0] a, output int start);
      nMem_Enable = 1'b0;
      mem_RW = rw;
      mem_address = a;
      @(posedge clk);
      #1;
      start = cyc;
      nMem_Enable = 1'b1;
   endtask

   task automatic read_mat(input logic [2:0] a, input logic [15:0] base, input logic [15:0] inc,
                           input string name);
      int s;
      for (int i = 0; i < 16; i++) exp_q.push_back(base + 16'(i) * inc);
      issue(1'b1, a, s);
      wait_done(s, 17, name);
   endtask

   task automatic write_mat(input logic [2:0] a, input logic [15:0] base, input logic [15:0] inc,
                            input int gap_after, input int gap_len, input int lat, input string name);
      int s;
      issue(1'b0, a, s);
      chk({name, "_ready"}, {31'h0, data_in_ready}, 1);
      for (int i = 0; i < 16; i++) begin
         data_in = base + 16'(i) * inc;
         data_in_valid = 1'b1;
         @(posedge clk);
         #1;
         if (i == gap_after) begin
            data_in_valid = 1'b0;
            data_in = 16'hDEAD;
            for (int g = 0; g < gap_len; g++) begin
               @(posedge clk);
               #1;
               chk({name, "_hold_idx"}, {28'h0, elem_index}, i + 1);
            end
         end
      end
      data_in_valid = 1'b0;
      wait_done(s, lat, name);
   endtask

   initial begin
      int s;
      bit seen;

      #12;
      chk("rst_busy", {31'h0, busy}, 0);
      chk("rst_ready", {31'h0, data_in_ready}, 0);
      chk("rst_dout", {16'h0, data_out}, 0);
      chk("rst_valid", {31'h0, data_out_valid}, 0);
      chk("rst_idx", {28'h0, elem_index}, 0);
      chk("rst_done", {31'h0, done}, 0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);

      // 1: fresh memory reads as zero
      read_mat(3'd3, 16'h0000, 16'h0000, "t1_rd");

      // 2: write then read back
      write_mat(3'd2, 16'h1000, 16'h0001, -1, 0, 17, "t2_wr");
      read_mat(3'd2, 16'h1000, 16'h0001, "t2_rd");
      chk("t2_hold_dout", {16'h0, data_out}, 32'h100F);

      // 3: valid gap of 3 cycles after element 5
      write_mat(3'd5, 16'h5000, 16'h0011, 5, 3, 20, "t3_wr");
      read_mat(3'd5, 16'h5000, 16'h0011, "t3_rd");

      // 4: strobe held low with address/direction churning mid-transfer
      write_mat(3'd1, 16'h2000, 16'h0001, -1, 0, 17, "t4_wr");
      for (int i = 0; i < 16; i++) exp_q.push_back(16'h2000 + 16'(i));
      nMem_Enable = 1'b0;
      mem_RW = 1'b1;
      mem_address = 3'd1;
      @(posedge clk);
      #1;
      s = cyc;
      seen = 0;
      for (int k = 0; k < 60; k++) begin
         mem_address = 3'(k + 2);
         mem_RW = logic'(k % 2);
         @(negedge clk);
         if (done) begin
            seen = 1;
            break;
         end
      end
      if (!seen) begin
         total++;
         bad++;
         $display("FAIL t4_timeout: got no done want done");
      end else begin
         chk("t4_lat", cyc - s, 17);
         chk("t4_busy_done", {31'h0, busy}, 0);
         mem_RW = 1'b1;
         mem_address = 3'd1;
         for (int i = 0; i < 16; i++) exp_q.push_back(16'h2000 + 16'(i));
         @(posedge clk);
         #1;
         s = cyc;
         nMem_Enable = 1'b1;
         chk("t4_reaccept", {31'h0, busy}, 1);
         wait_done(s, 17, "t4_rd2");
      end
      nMem_Enable = 1'b1;

      // 5: asynchronous reset mid-read
      write_mat(3'd4, 16'h4000, 16'h0001, -1, 0, 17, "t5_wr");
      for (int i = 0; i < 8; i++) exp_q.push_back(16'h4000 + 16'(i));
      issue(1'b1, 3'd4, s);
      repeat (8) @(posedge clk);
      @(negedge clk);
      #1;
      reset = 1'b0;
      #1;
      chk("t5_dout", {16'h0, data_out}, 0);
      chk("t5_valid", {31'h0, data_out_valid}, 0);
      chk("t5_busy", {31'h0, busy}, 0);
      chk("t5_idx", {28'h0, elem_index}, 0);
      chk("t5_q", exp_q.size(), 0);
      #1;
      reset = 1'b1;
      @(negedge clk);
      read_mat(3'd4, 16'h0000, 16'h0000, "t5_rd");

      // 6: neighbours untouched by a full write
      write_mat(3'd7, 16'hFFFF, 16'h0000, -1, 0, 17, "t6_wr");
      read_mat(3'd0, 16'h0000, 16'h0000, "t6_rd0");
      read_mat(3'd6, 16'h0000, 16'h0000, "t6_rd6");
      read_mat(3'd7, 16'hFFFF, 16'h0000, "t6_rd7");

      repeat (2) @(negedge clk);
      chk("queue_empty", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
